// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers and the MixColumns sequencer FSM encodings.
// The inverse multipliers exist only when MIX_COLUMNS_INV_EN is defined.
package aes_pkg;

    localparam logic [7:0] AES_RED_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_RED_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Inverse coefficients built from the x2/x4/x8 chain.
    function automatic logic [7:0] gf_mul09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction
`endif

endpackage

// File: rtl/mix_column_single.sv
// Combinational MixColumns of one 32-bit column (row 0 in the top byte).
// With MIX_COLUMNS_INV_EN defined, inv_i selects InvMixColumns.
module mix_column_single
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
`ifdef MIX_COLUMNS_INV_EN
    input  logic        inv_i,
`endif
    output logic [31:0] col_o
);

    logic [7:0] a0_s, a1_s, a2_s, a3_s;

    assign a0_s = col_i[31:24];
    assign a1_s = col_i[23:16];
    assign a2_s = col_i[15:8];
    assign a3_s = col_i[7:0];

    // Circulant matrix multiply of the column.
    always_comb begin
`ifdef MIX_COLUMNS_INV_EN
        if (inv_i) begin
            col_o = {gf_mul0e(a0_s) ^ gf_mul0b(a1_s) ^ gf_mul0d(a2_s) ^ gf_mul09(a3_s),
                     gf_mul09(a0_s) ^ gf_mul0e(a1_s) ^ gf_mul0b(a2_s) ^ gf_mul0d(a3_s),
                     gf_mul0d(a0_s) ^ gf_mul09(a1_s) ^ gf_mul0e(a2_s) ^ gf_mul0b(a3_s),
                     gf_mul0b(a0_s) ^ gf_mul0d(a1_s) ^ gf_mul09(a2_s) ^ gf_mul0e(a3_s)};
        end else begin
            col_o = {gf_mul2(a0_s) ^ gf_mul3(a1_s) ^ a2_s ^ a3_s,
                     a0_s ^ gf_mul2(a1_s) ^ gf_mul3(a2_s) ^ a3_s,
                     a0_s ^ a1_s ^ gf_mul2(a2_s) ^ gf_mul3(a3_s),
                     gf_mul3(a0_s) ^ a1_s ^ a2_s ^ gf_mul2(a3_s)};
        end
`else
        col_o = {gf_mul2(a0_s) ^ gf_mul3(a1_s) ^ a2_s ^ a3_s,
                 a0_s ^ gf_mul2(a1_s) ^ gf_mul3(a2_s) ^ a3_s,
                 a0_s ^ a1_s ^ gf_mul2(a2_s) ^ gf_mul3(a3_s),
                 gf_mul3(a0_s) ^ a1_s ^ a2_s ^ gf_mul2(a3_s)};
`endif
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one column per cycle, fixed 4-cycle latency, valid/ready handshakes.
// Optional macro MIX_COLUMNS_INV_EN adds the inv port selecting InvMixColumns.
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         last_round,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    mc_state_e    state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic         last_q, last_d;
    logic [31:0]  col_sel_s, col_mix_s, col_new_s;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv_q, inv_d;
`endif

    // Column currently being transformed.
    always_comb begin
        case (col_q)
            2'd0:    col_sel_s = work_q[127:96];
            2'd1:    col_sel_s = work_q[95:64];
            2'd2:    col_sel_s = work_q[63:32];
            2'd3:    col_sel_s = work_q[31:0];
            default: col_sel_s = 32'h0000_0000;
        endcase
    end

    mix_column_single u_mix (
        .col_i (col_sel_s),
`ifdef MIX_COLUMNS_INV_EN
        .inv_i (inv_q),
`endif
        .col_o (col_mix_s)
    );

    // Final round still walks all four columns so latency stays constant.
    assign col_new_s = last_q ? col_sel_s : col_mix_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_CALC;
                else          state_d = ST_IDLE;
            end
            ST_CALC: begin
                if (col_q == 2'd3) state_d = ST_DONE;
                else               state_d = ST_CALC;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
                else           state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_CALC: busy      = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath registers: working state, column counter, latched controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= 128'h0;
            col_q  <= 2'd0;
            last_q <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q  <= 1'b0;
`endif
        end else begin
            work_q <= work_d;
            col_q  <= col_d;
            last_q <= last_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q  <= inv_d;
`endif
        end
    end

    // Datapath next-state: load on acceptance, write back one column per CALC cycle.
    always_comb begin
        work_d = work_q;
        col_d  = col_q;
        last_d = last_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d  = inv_q;
`endif
        if (state_q == ST_IDLE && in_valid) begin
            work_d = in_state;
            col_d  = 2'd0;
            last_d = last_round;
`ifdef MIX_COLUMNS_INV_EN
            inv_d  = inv;
`endif
        end else if (state_q == ST_CALC) begin
            case (col_q)
                2'd0:    work_d[127:96] = col_new_s;
                2'd1:    work_d[95:64]  = col_new_s;
                2'd2:    work_d[63:32]  = col_new_s;
                2'd3:    work_d[31:0]   = col_new_s;
                default: work_d = work_q;
            endcase
            col_d = col_q + 2'd1;
        end else begin
            work_d = work_q;
        end
    end

    assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: driver pushes expected results at acceptance,
// a negedge monitor pops and checks data, 4-cycle latency and hold stability.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         last_round;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    typedef struct {
        logic [127:0] data;
        bit           check;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] pend_data;
    bit           pend_check;
    int           cyc = 0;
    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [127:0] last_out;
    logic [127:0] held;
    bit           holding = 1'b0;

    always #5 clk = ~clk;

    mix_columns_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .last_round (last_round),
`ifdef MIX_COLUMNS_INV_EN
        .inv        (inv),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Acceptance observer: records the expected result and acceptance cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset && in_valid && in_ready) begin
            sb_q.push_back('{data: pend_data, check: pend_check, cyc: cyc});
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (!holding) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 128'd1, 128'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.check) chk("out_state", out_state, e.data);
                    chk("latency", 128'(cyc - e.cyc), 128'd4);
                end
                held     = out_state;
                last_out = out_state;
                holding  = 1'b1;
            end else begin
                chk("hold_stable", out_state, held);
            end
            if (out_ready) holding = 1'b0;
        end else begin
            holding = 1'b0;
        end
    end

    task automatic send(input logic [127:0] st, input logic lr, input logic iv,
                        input logic [127:0] exp, input bit check);
        bit r;
        bit ok = 1'b0;
        pend_data  = exp;
        pend_check = check;
        in_state   = st;
        last_round = lr;
        inv        = iv;
        in_valid   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        in_valid   = 1'b0;
        in_state   = ~st;
        last_round = ~lr;
        inv        = ~iv;
        if (!ok) chk("accept_timeout", 128'd1, 128'd0);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 128'd1, 128'd0);
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V3     = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_state   = 128'h0;
        last_round = 1'b0;
        inv        = 1'b0;
        out_ready  = 1'b1;
        pend_data  = 128'h0;
        pend_check = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_out_state", out_state, 128'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        send(V1_IN, 1'b0, 1'b0, V1_OUT, 1'b1);
        wait_idle();
        send(V2_IN, 1'b0, 1'b0, V2_OUT, 1'b1);
        wait_idle();
        send(V3, 1'b1, 1'b0, V3, 1'b1);
        wait_idle();
        send(V1_IN, 1'b1, 1'b0, V1_IN, 1'b1);
        wait_idle();

        // Back-to-back blocks.
        send(V2_IN, 1'b0, 1'b0, V2_OUT, 1'b1);
        send(V1_IN, 1'b0, 1'b0, V1_OUT, 1'b1);
        wait_idle();

        // Backpressure with ignored in_valid pulses.
        out_ready = 1'b0;
        send(V2_IN, 1'b0, 1'b0, V2_OUT, 1'b1);
        repeat (4) @(posedge clk);
        pend_data  = 128'hdead_beef;
        pend_check = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            in_valid = i[0];
            in_state = V3 ^ 128'(i);
            @(negedge clk);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(V1_IN, 1'b0, 1'b0, V1_OUT, 1'b1);
        wait_idle();

        // Reset during CALC at col==2 aborts without output.
        send(V2_IN, 1'b0, 1'b0, V2_OUT, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_out_state", out_state, 128'h0);
        chk("abort_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        send(V1_IN, 1'b0, 1'b0, V1_OUT, 1'b1);
        wait_idle();

`ifdef MIX_COLUMNS_INV_EN
        send(V1_OUT, 1'b0, 1'b1, V1_IN, 1'b1);
        wait_idle();
        send(V3, 1'b1, 1'b1, V3, 1'b1);
        wait_idle();
        for (int n = 0; n < 1000; n++) begin
            logic [127:0] r;
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(r, 1'b0, 1'b0, 128'h0, 1'b0);
            wait_idle();
            send(last_out, 1'b0, 1'b1, r, 1'b1);
            wait_idle();
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
